// File: rtl/ahblite_resp_mux_pkg.sv
// Shared encodings for the AHB-Lite data-phase response mux and its default slave.
package ahblite_resp_mux_pkg;

  localparam int NUM_SLV_DEF = 17;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SLV  = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } st_e;

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers every started transfer with the two-cycle AHB ERROR response.
module ahblite_default_slave
  import ahblite_resp_mux_pkg::*;
(
  input  logic gclk,
  input  logic grst_n,
  input  logic start,
  output logic hreadyout,
  output logic hresp
);

  st_e st;

  // ERR1 always runs into ERR2; a new error may be started from ERR2 (HREADY=1 there).
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      st <= ST_IDLE;
    end else if (st == ST_ERR1) begin
      st <= ST_ERR2;
    end else begin
      st <= start ? ST_ERR1 : ST_IDLE;
    end
  end

  assign hreadyout = (st != ST_ERR1);
  assign hresp     = (st == ST_ERR1 || st == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahblite_resp_mux.sv
// AHB-Lite data-phase response mux: registers the decoder select and returns the
// selected slave's HRDATA/HREADY/HRESP, or a default-slave ERROR for bad addresses.
module ahblite_resp_mux
  import ahblite_resp_mux_pkg::*;
#(
  parameter int NUM_SLV = NUM_SLV_DEF,
  parameter int DW      = 32
) (
  input  logic                   HCLK,
  input  logic                   HRESETN,
  input  logic [NUM_SLV-1:0]     HSEL_DEC,
  input  logic                   ADDR_INVALID,
  input  logic [1:0]             HTRANS,
  input  logic [NUM_SLV*DW-1:0]  SLV_HRDATA,
  input  logic [NUM_SLV-1:0]     SLV_HREADYOUT,
  input  logic [NUM_SLV-1:0]     SLV_HRESP,
  output logic [NUM_SLV-1:0]     HSEL_S,
  output logic                   HREADY,
  output logic                   HRESP,
  output logic [DW-1:0]          HRDATA
);

  function automatic logic is_onehot(input logic [NUM_SLV-1:0] v);
    return ($countones(v) == 1);
  endfunction

  st_e               st;
  logic [NUM_SLV-1:0] sel_q;
  logic              addr_ok, valid_sel, ds_start, ds_rdy, ds_resp;
  logic [DW-1:0]     mux_data;
  logic              mux_rdy, mux_resp;

  assign HSEL_S    = HSEL_DEC & ~{NUM_SLV{ADDR_INVALID}};
  assign addr_ok   = HREADY & (HTRANS == HT_NONSEQ || HTRANS == HT_SEQ);
  assign valid_sel = is_onehot(HSEL_DEC) & ~ADDR_INVALID;
  assign ds_start  = addr_ok & ~valid_sel;

  ahblite_default_slave u_dflt (
    .gclk      (HCLK),
    .grst_n    (HRESETN),
    .start     (ds_start),
    .hreadyout (ds_rdy),
    .hresp     (ds_resp)
  );

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      st    <= ST_IDLE;
      sel_q <= '0;
    end else if (st == ST_ERR1) begin
      st <= ST_ERR2;
    end else if (HREADY) begin
      if (addr_ok && valid_sel) begin
        st    <= ST_SLV;
        sel_q <= HSEL_DEC;
      end else if (addr_ok) begin
        st    <= ST_ERR1;
        sel_q <= '0;
      end else begin
        st    <= ST_IDLE;
        sel_q <= '0;
      end
    end
  end

  // AND-OR mux: unselected slots are masked by a 0 in sel_q, so X there cannot leak.
  always_comb begin
    mux_data = '0;
    mux_rdy  = 1'b0;
    mux_resp = 1'b0;
    for (int k = 0; k < NUM_SLV; k++) begin
      mux_data = mux_data | ({DW{sel_q[k]}} & SLV_HRDATA[k*DW +: DW]);
      mux_rdy  = mux_rdy  | (sel_q[k] & SLV_HREADYOUT[k]);
      mux_resp = mux_resp | (sel_q[k] & SLV_HRESP[k]);
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    case (st)
      ST_SLV: begin
        HREADY = mux_rdy;
        HRESP  = mux_resp;
        HRDATA = mux_data;
      end
      ST_ERR1, ST_ERR2: begin
        HREADY = ds_rdy;
        HRESP  = ds_resp;
      end
      default: ;
    endcase
  end

endmodule
